fetch_unit: RTL

Instruction fetch stage of the dual-issue front end. Owns the even program counter, issues paired-word reads to instruction memory, and presents the even/odd instruction pair (p0/p1) to the branch unit and decode. It consumes the branch unit's next-PC, odd-target and squash signals. It absorbs memory grant loss and downstream stalls with a one-entry hold buffer.

---
 rtl/fetch_unit.sv | 70 +++++++
 1 files changed

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - dual-issue instruction fetch stage with one-entry hold buffer
// Issues a paired-word read every cycle and presents the even/odd pair to decode.
module fetch_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [8:0]  PC_next_in,
  input  logic        IR0_invalid_in,
  input  logic        reset_S1_in,
  input  logic        stall_in,
  output logic [7:0]  imem_addr_out,
  input  logic        imem_gnt_in,
  input  logic [31:0] imem_rdata_in,
  output logic [8:0]  PC_out,
  output logic        fetch_next_out,
  output logic [15:0] p0_IR_out,
  output logic [15:0] p1_IR_out,
  output logic        p0_valid_out,
  output logic        p1_valid_out,
  output logic [15:0] bubble_cnt_out
);

  logic [7:0]  pc_q;
  logic        gnt_q;
  logic        hold_valid;
  logic [31:0] hold_data;
  logic [15:0] bubble_cnt;
  logic        avail;
  logic [31:0] pair_data;
  logic        unused_pc_lsb;

  // The PC is always even, so only the pair address is stored.
  assign unused_pc_lsb = PC_next_in[0];

  assign avail          = hold_valid | gnt_q;
  assign pair_data      = hold_valid ? hold_data : imem_rdata_in;
  assign fetch_next_out = avail & ~stall_in;

  // Issuing the next address on advance keeps returning data aligned with the held PC.
  assign imem_addr_out  = fetch_next_out ? PC_next_in[8:1] : pc_q;

  assign PC_out         = {pc_q, 1'b0};
  assign p1_valid_out   = avail & ~reset_S1_in;
  assign p0_valid_out   = p1_valid_out & ~IR0_invalid_in;
  assign p0_IR_out      = p0_valid_out ? pair_data[15:0]  : 16'h0000;
  assign p1_IR_out      = p1_valid_out ? pair_data[31:16] : 16'h0000;
  assign bubble_cnt_out = bubble_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= 8'h00;
      gnt_q      <= 1'b0;
      hold_valid <= 1'b0;
      hold_data  <= 32'h0000_0000;
      bubble_cnt <= 16'h0000;
    end else begin
      gnt_q <= imem_gnt_in;
      if (fetch_next_out) begin
        pc_q       <= PC_next_in[8:1];
        hold_valid <= 1'b0;
      end else if (gnt_q && !hold_valid && stall_in) begin
        hold_valid <= 1'b1;
        hold_data  <= imem_rdata_in;
      end
      if (!avail && bubble_cnt != 16'hFFFF) begin
        bubble_cnt <= bubble_cnt + 16'd1;
      end
    end
  end

endmodule
